// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - programmable interrupt controller with edge/level sources, mask, claim
// Synchronised sources feed pending/active logic; eff bits are folded onto N_OUT HWInt lines.
module irq_ctrl #(
  parameter int N_SRC       = 16,
  parameter int N_OUT       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src_in,
  input  logic             i_sel,
  input  logic [2:0]       i_addr,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_be,
  output logic [31:0]      o_rdata,
  output logic [N_OUT-1:0] o_irq_out,
  output logic             o_irq_any
);

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_MODE  = 3'd2;
  localparam logic [2:0] A_POL   = 3'd3;
  localparam logic [2:0] A_CLAIM = 3'd4;
  localparam logic [2:0] A_RAW   = 3'd5;

  logic [N_SRC-1:0] r_sync [SYNC_STAGES];
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_pol;
  logic [N_OUT-1:0] r_irq_out;
  logic             r_irq_any;

  logic [N_SRC-1:0] w_raw_s;
  logic [N_SRC-1:0] w_n_cur;
  logic [N_SRC-1:0] w_n_prev;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_eff;
  logic [31:0]      w_bmask32;
  logic [31:0]      w_wd32;
  logic [N_SRC-1:0] w_bm;
  logic [N_SRC-1:0] w_wd;
  logic             w_wr;
  logic [N_SRC-1:0] w_mask_next;
  logic [N_SRC-1:0] w_mode_next;
  logic [N_SRC-1:0] w_pol_next;
  logic [N_SRC-1:0] w_mode_fall;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_claim_clr;
  logic [N_SRC-1:0] w_claim_hot;
  logic [5:0]       w_claim_id;
  logic [N_SRC-1:0] w_pend_next;
  logic [N_OUT-1:0] w_irq_map;
  logic [31:0]      w_rd;
  logic             w_unused_hi;

  assign w_raw_s  = r_sync[SYNC_STAGES-1];
  // Both sides use the current polarity so a polarity write cannot fake an edge.
  assign w_n_cur  = w_raw_s ^ r_pol;
  assign w_n_prev = r_prev ^ r_pol;
  assign w_rise   = w_n_cur & ~w_n_prev & r_mode;
  assign w_active = (r_mode & r_pend) | (~r_mode & w_n_cur);
  assign w_eff    = w_active & r_mask;

  assign w_bmask32 = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
  assign w_wd32    = i_wdata & w_bmask32;
  assign w_bm      = w_bmask32[N_SRC-1:0];
  assign w_wd      = w_wd32[N_SRC-1:0];
  assign w_unused_hi = ^{w_bmask32, w_wd32};
  assign w_wr      = i_sel & i_we;

  assign w_mask_next = (w_wr && i_addr == A_MASK) ? ((r_mask & ~w_bm) | w_wd) : r_mask;
  assign w_mode_next = (w_wr && i_addr == A_MODE) ? ((r_mode & ~w_bm) | w_wd) : r_mode;
  assign w_pol_next  = (w_wr && i_addr == A_POL)  ? ((r_pol  & ~w_bm) | w_wd) : r_pol;
  assign w_mode_fall = r_mode & ~w_mode_next;
  assign w_w1c       = (w_wr && i_addr == A_PEND) ? (w_wd & r_mode) : '0;

  always_comb begin
    w_claim_id  = '0;
    w_claim_hot = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eff[i]) begin
        w_claim_id     = 6'(i + 1);
        w_claim_hot    = '0;
        w_claim_hot[i] = 1'b1;
      end
    end
  end

  assign w_claim_clr = (i_sel && i_re && i_addr == A_CLAIM) ? (w_claim_hot & r_mode) : '0;

  // A new edge beats a same-cycle W1C or claim; leaving edge mode drops stored state.
  assign w_pend_next = ((r_pend & ~w_w1c & ~w_claim_clr) | w_rise) & ~w_mode_fall;

  always_comb begin
    w_irq_map = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_irq_map[i % N_OUT] = w_irq_map[i % N_OUT] | w_eff[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_prev    <= '0;
      r_pend    <= '0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_pol     <= '0;
      r_irq_out <= '0;
      r_irq_any <= 1'b0;
    end else begin
      r_sync[0] <= i_src_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev    <= w_raw_s;
      r_pend    <= w_pend_next;
      r_mask    <= w_mask_next;
      r_mode    <= w_mode_next;
      r_pol     <= w_pol_next;
      r_irq_out <= w_irq_map;
      r_irq_any <= |w_eff;
    end
  end

  always_comb begin
    w_rd = '0;
    if (i_sel) begin
      case (i_addr)
        A_PEND:  w_rd[N_SRC-1:0] = w_active;
        A_MASK:  w_rd[N_SRC-1:0] = r_mask;
        A_MODE:  w_rd[N_SRC-1:0] = r_mode;
        A_POL:   w_rd[N_SRC-1:0] = r_pol;
        A_CLAIM: w_rd[5:0]       = w_claim_id;
        A_RAW:   w_rd[N_SRC-1:0] = w_raw_s;
        default: w_rd = '0;
      endcase
    end
  end

  assign o_rdata   = w_rd;
  assign o_irq_out = r_irq_out;
  assign o_irq_any = r_irq_any;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_src_in;
  logic        i_sel;
  logic [2:0]  i_addr;
  logic        i_we;
  logic        i_re;
  logic [31:0] i_wdata;
  logic [3:0]  i_be;
  logic [31:0] o_rdata;
  logic [5:0]  o_irq_out;
  logic        o_irq_any;

  int n_checks;
  int n_errors;

  irq_ctrl #(.N_SRC(16), .N_OUT(6), .SYNC_STAGES(2)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_src_in  (i_src_in),
    .i_sel     (i_sel),
    .i_addr    (i_addr),
    .i_we      (i_we),
    .i_re      (i_re),
    .i_wdata   (i_wdata),
    .i_be      (i_be),
    .o_rdata   (o_rdata),
    .o_irq_out (o_irq_out),
    .o_irq_any (o_irq_any)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d; i_be = b;
    tick();
    i_sel = 1'b0; i_we = 1'b0; i_wdata = '0; i_be = '0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    i_sel = 1'b1; i_re = 1'b0; i_addr = a;
    #1;
    d = o_rdata;
    i_sel = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    i_sel = 1'b1; i_re = 1'b1; i_addr = a;
    #1;
    d = o_rdata;
    tick();
    i_sel = 1'b0; i_re = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_rst = 1'b0; i_src_in = '0; i_sel = 1'b0; i_addr = '0;
    i_we = 1'b0; i_re = 1'b0; i_wdata = '0; i_be = '0;
    #3;
    check("rst_irq_out", {26'b0, o_irq_out}, 32'h0);
    check("rst_irq_any", {31'b0, o_irq_any}, 32'h0);
    check("rdata_nosel", o_rdata, 32'h0);
    tick(); tick();
    i_rst = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) begin
      peek(3'(a), v);
      check($sformatf("reset_reg%0d", a), v, 32'h0);
    end

    // all sources active but masked
    i_src_in = 16'hFFFF;
    repeat (5) tick();
    check("masked_irq_out", {26'b0, o_irq_out}, 32'h0);
    check("masked_irq_any", {31'b0, o_irq_any}, 32'h0);
    peek(3'd4, v); check("masked_claim", v, 32'h0);
    peek(3'd0, v); check("masked_pend_level", v, 32'h0000FFFF);
    peek(3'd5, v); check("raw_all", v, 32'h0000FFFF);
    i_src_in = '0;
    repeat (4) tick();

    // edge source 0, latency and claim
    wr(3'd1, 32'h1, 4'hF);
    wr(3'd2, 32'h1, 4'hF);
    peek(3'd1, v); check("mask_rb", v, 32'h1);
    peek(3'd2, v); check("mode_rb", v, 32'h1);
    i_src_in = 16'h0001;
    tick();
    i_src_in = '0;
    peek(3'd0, v); check("e0_pend_edge1", v, 32'h0);
    tick();
    peek(3'd0, v); check("e0_pend_edge2", v, 32'h0);
    peek(3'd5, v); check("e0_raw_edge2", v, 32'h1);
    tick();
    peek(3'd0, v); check("e0_pend_edge3", v, 32'h1);
    check("e0_irq_edge3", {26'b0, o_irq_out}, 32'h0);
    tick();
    check("e0_irq_edge4", {26'b0, o_irq_out}, 32'h1);
    check("e0_any_edge4", {31'b0, o_irq_any}, 32'h1);
    rd(3'd4, v); check("e0_claim", v, 32'h1);
    peek(3'd0, v); check("e0_pend_after_claim", v, 32'h0);
    tick();
    check("e0_irq_cleared", {26'b0, o_irq_out}, 32'h0);
    check("e0_any_cleared", {31'b0, o_irq_any}, 32'h0);

    // level source 7 folds onto irq_out[1]
    wr(3'd2, 32'h0, 4'hF);
    wr(3'd1, 32'h80, 4'hF);
    i_src_in = 16'h0080;
    repeat (4) tick();
    check("lvl7_irq_out", {26'b0, o_irq_out}, 32'h2);
    rd(3'd4, v); check("lvl7_claim_a", v, 32'h8);
    rd(3'd4, v); check("lvl7_claim_b", v, 32'h8);
    peek(3'd0, v); check("lvl7_pend", v, 32'h80);
    i_src_in = '0;
    tick(); tick();
    peek(3'd0, v); check("lvl7_pend_drop", v, 32'h0);
    tick();
    check("lvl7_irq_drop", {26'b0, o_irq_out}, 32'h0);

    // active-low edge on source 3
    i_src_in = 16'h0008;
    repeat (4) tick();
    wr(3'd3, 32'h8, 4'hF);
    wr(3'd2, 32'h8, 4'hF);
    wr(3'd1, 32'h8, 4'hF);
    repeat (4) tick();
    peek(3'd0, v); check("pol3_no_pend", v, 32'h0);
    i_src_in = '0;
    tick(); tick();
    peek(3'd0, v); check("pol3_pend_edge2", v, 32'h0);
    tick();
    peek(3'd0, v); check("pol3_pend_edge3", v, 32'h8);
    wr(3'd0, 32'h8, 4'hF);
    peek(3'd0, v); check("pol3_w1c", v, 32'h0);
    wr(3'd3, 32'h0, 4'hF);

    // edge on source 2 coinciding with W1C: set wins
    wr(3'd2, 32'h4, 4'hF);
    wr(3'd1, 32'h4, 4'hF);
    i_src_in = 16'h0004;
    repeat (3) tick();
    peek(3'd0, v); check("s2_first_pend", v, 32'h4);
    i_src_in = '0;
    repeat (3) tick();
    i_src_in = 16'h0004;
    tick(); tick();
    wr(3'd0, 32'h4, 4'hF);
    peek(3'd0, v); check("s2_set_wins", v, 32'h4);
    wr(3'd0, 32'h4, 4'hF);
    peek(3'd0, v); check("s2_w1c_alone", v, 32'h0);

    // sources 4 and 9 pending: lowest index claims first
    i_src_in = '0;
    wr(3'd2, 32'h210, 4'hF);
    wr(3'd1, 32'h210, 4'hF);
    i_src_in = 16'h0210;
    repeat (4) tick();
    peek(3'd4, v); check("claim_peek_5", v, 32'h5);
    rd(3'd4, v); check("claim_5", v, 32'h5);
    peek(3'd0, v); check("pend_after_5", v, 32'h200);
    rd(3'd4, v); check("claim_10", v, 32'hA);
    peek(3'd0, v); check("pend_after_10", v, 32'h0);
    peek(3'd4, v); check("claim_empty", v, 32'h0);

    // byte enables, width clipping, unused offsets, RO writes
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd1, 32'hFFFFFFFF, 4'b0001);
    peek(3'd1, v); check("mask_be0", v, 32'h000000FF);
    wr(3'd1, 32'hFFFFFFFF, 4'hF);
    peek(3'd1, v); check("mask_clip", v, 32'h0000FFFF);
    wr(3'd6, 32'hFFFFFFFF, 4'hF);
    peek(3'd6, v); check("addr6_zero", v, 32'h0);
    peek(3'd7, v); check("addr7_zero", v, 32'h0);
    wr(3'd5, 32'hFFFFFFFF, 4'hF);
    peek(3'd5, v); check("raw_ro", v, 32'h0210);

    // async reset with a pending interrupt
    i_src_in = '0;
    wr(3'd1, 32'h1, 4'hF);
    wr(3'd2, 32'h1, 4'hF);
    repeat (3) tick();
    i_src_in = 16'h0001;
    tick();
    i_src_in = '0;
    repeat (3) tick();
    check("pre_rst_irq", {26'b0, o_irq_out}, 32'h1);
    #2;
    i_rst = 1'b0;
    #1;
    check("async_rst_irq", {26'b0, o_irq_out}, 32'h0);
    check("async_rst_any", {31'b0, o_irq_any}, 32'h0);
    peek(3'd0, v); check("async_rst_pend", v, 32'h0);
    peek(3'd1, v); check("async_rst_mask", v, 32'h0);
    tick();
    i_rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
